// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: opcodes, FSM states, fault codes
// and byte positions within a 32-bit instruction word.
package seq_pkg;

  localparam logic [5:0] OP_CALL = 6'h30;
  localparam logic [5:0] OP_RET  = 6'h31;
  localparam logic [5:0] OP_HALT = 6'h32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_EXEC,
    ST_HALT,
    ST_FAULT
  } state_t;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_OVF  = 2'b01;
  localparam logic [1:0] FAULT_UNF  = 2'b10;

  localparam int unsigned BYTE_OPCODE = 0;
  localparam int unsigned BYTE_ARG1   = 1;
  localparam int unsigned BYTE_ARG2   = 2;
  localparam int unsigned BYTE_DEST   = 3;

  localparam logic [7:0] PC_STEP = 8'd4;

endpackage

// File: rtl/prog_sequencer_ret_stack.sv
// Return-address LIFO for CALL/RET; dout always shows the top entry.
// push and pop are never asserted together.
module ret_stack #(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0] SP_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [STACK_DEPTH];
  logic [7:0]  mem_d [STACK_DEPTH];
  logic [AW:0] sp_q, sp_d;
  logic [AW:0] top_idx;

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push && !full) begin
      mem_d[sp_q[AW-1:0]] = din;
      sp_d = sp_q + SP_ONE;
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_ONE;
    end
  end

  always_comb begin
    top_idx = sp_q - SP_ONE;
    dout    = mem_q[top_idx[AW-1:0]];
    full    = (sp_q == (AW+1)'(STACK_DEPTH));
    empty   = (sp_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches from the instruction ROM, handles CALL/RET/HALT
// locally and hands every other instruction to the execute unit.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        exec_done,
  input  logic        exec_redirect,
  input  logic [7:0]  exec_target,
  output logic [7:0]  pc,
  output logic        halted,
  output logic [1:0]  fault
);

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  rom_addr_q;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [1:0]  fault_q, fault_d;

  logic        stk_push, stk_pop;
  logic [7:0]  stk_dout;
  logic        stk_full, stk_empty;
  logic [5:0]  opcode;
  logic        next_fetch;

  ret_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_q + PC_STEP),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // rom_addr is its own register loaded with the same next value as pc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      rom_addr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= FAULT_NONE;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rom_addr_q    <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    opcode        = rom_data[BYTE_OPCODE*8 +: 6];
    next_fetch    = run;
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode)
          OP_CALL: begin
            if (stk_full) begin
              fault_d = FAULT_OVF;
              state_d = ST_FAULT;
            end else begin
              stk_push = 1'b1;
              pc_d     = rom_data[BYTE_ARG2*8 +: 8];
              state_d  = next_fetch ? ST_FETCH : ST_IDLE;
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              fault_d = FAULT_UNF;
              state_d = ST_FAULT;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_dout;
              state_d = next_fetch ? ST_FETCH : ST_IDLE;
            end
          end
          OP_HALT: begin
            state_d = ST_HALT;
          end
          default: begin
            instr_d       = rom_data;
            instr_valid_d = 1'b1;
            state_d       = ST_ISSUE;
          end
        endcase
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          pc_d    = exec_redirect ? exec_target : pc_q + PC_STEP;
          state_d = next_fetch ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT, ST_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pc          = pc_q;
    rom_addr    = rom_addr_q;
    instr       = instr_q;
    instr_valid = instr_valid_q;
    halted      = (state_q == ST_HALT);
    fault       = fault_q;
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios plus randomized
// programs, compared against an instruction-level reference model.
module tb_prog_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic        exec_redirect = 1'b0;
  logic [7:0]  exec_target = '0;
  logic [7:0]  pc;
  logic        halted;
  logic [1:0]  fault;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem [256];

  logic [7:0] m_pc;
  logic [7:0] m_stack [$];
  logic [1:0] m_fault;
  bit         m_dead;

  prog_sequencer #(.STACK_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .exec_done    (exec_done),
    .exec_redirect(exec_redirect),
    .exec_target  (exec_target),
    .pc           (pc),
    .halted       (halted),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  // ROM: one-cycle registered read of four consecutive bytes
  always @(posedge clk) rom_data <= word_at(rom_addr);

  task automatic put_word(input logic [7:0] a, input logic [31:0] w);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = a + 8'(i);
      mem[b] = w[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] alu_word();
    logic [31:0] w;
    w = $urandom;
    while (w[5:0] == 6'h30 || w[5:0] == 6'h31 || w[5:0] == 6'h32) w[5:0] = 6'($urandom);
    return w;
  endfunction

  function automatic logic [31:0] ctl_word(input logic [5:0] op, input logic [7:0] tgt);
    return {8'($urandom), tgt, 8'($urandom), 2'($urandom), op};
  endfunction

  task automatic fill_alu();
    for (int a = 0; a < 256; a += 4) put_word(8'(a), alu_word());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_pc = 8'h00;
    m_stack.delete();
    m_fault = 2'b00;
    m_dead = 1'b0;
  endtask

  task automatic check_reset_values(input string where);
    chk({where, "_pc"}, pc, 0);
    chk({where, "_rom_addr"}, rom_addr, 0);
    chk({where, "_instr"}, instr, 0);
    chk({where, "_valid"}, instr_valid, 0);
    chk({where, "_halted"}, halted, 0);
    chk({where, "_fault"}, fault, 0);
  endtask

  // Leaves the DUT in FETCH at a negedge with run high
  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    instr_ready = 1'b0;
    exec_done = 1'b0;
    exec_redirect = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_model();
    rst = 1'b0;
    run = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_stuck(input logic exp_halted);
    repeat (3) begin
      instr_ready = 1'($urandom);
      exec_done = 1'($urandom);
      exec_redirect = 1'b1;
      exec_target = 8'($urandom);
      run = 1'($urandom);
      @(negedge clk);
      chk("stuck_pc", pc, m_pc);
      chk("stuck_rom_addr", rom_addr, m_pc);
      chk("stuck_halted", halted, exp_halted);
      chk("stuck_fault", fault, m_fault);
      chk("stuck_valid", instr_valid, 0);
    end
    instr_ready = 1'b0;
    exec_done = 1'b0;
    exec_redirect = 1'b0;
    run = 1'b1;
  endtask

  // One instruction from its FETCH cycle to the FETCH of the next one
  task automatic exec_one(input int rdly, input int ddly, input bit redir,
                          input logic [7:0] tgt, input bit gap, input bit rst_exec);
    logic [31:0] w;
    logic [5:0]  op;
    w  = word_at(m_pc);
    op = w[5:0];
    chk("fetch_pc", pc, m_pc);
    chk("fetch_rom_addr", rom_addr, m_pc);
    chk("fetch_valid", instr_valid, 0);
    @(negedge clk);
    chk("decode_pc", pc, m_pc);
    chk("decode_valid", instr_valid, 0);
    @(negedge clk);
    if (op == 6'h30 || op == 6'h31) begin
      if (op == 6'h30) begin
        if (m_stack.size() >= DEPTH) m_fault = 2'b01;
        else begin
          m_stack.push_back(m_pc + 8'd4);
          m_pc = w[23:16];
        end
      end else begin
        if (m_stack.size() == 0) m_fault = 2'b10;
        else m_pc = m_stack.pop_back();
      end
      chk("ctl_fault", fault, m_fault);
      chk("ctl_pc", pc, m_pc);
      chk("ctl_rom_addr", rom_addr, m_pc);
      chk("ctl_valid", instr_valid, 0);
      chk("ctl_halted", halted, 0);
      if (m_fault != 2'b00) begin
        m_dead = 1'b1;
        check_stuck(1'b0);
      end
    end else if (op == 6'h32) begin
      m_dead = 1'b1;
      chk("halt_halted", halted, 1);
      chk("halt_valid", instr_valid, 0);
      chk("halt_pc", pc, m_pc);
      check_stuck(1'b1);
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        chk("issue_valid", instr_valid, 1);
        chk("issue_instr", instr, w);
        chk("issue_pc", pc, m_pc);
        instr_ready = (i == rdly);
        exec_done = (i < rdly) ? 1'($urandom) : 1'b0;
        exec_redirect = 1'b1;
        exec_target = 8'($urandom);
        @(negedge clk);
      end
      instr_ready = 1'b0;
      exec_done = 1'b0;
      exec_redirect = 1'b0;
      chk("exec_valid", instr_valid, 0);
      chk("exec_instr_held", instr, w);
      if (rst_exec) begin
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        reset_model();
        return;
      end
      if (gap) run = 1'b0;
      for (int i = 0; i <= ddly; i++) begin
        chk("exec_pc", pc, m_pc);
        exec_done = (i == ddly);
        exec_redirect = redir;
        exec_target = tgt;
        @(negedge clk);
      end
      exec_done = 1'b0;
      exec_redirect = 1'b0;
      m_pc = redir ? tgt : m_pc + 8'd4;
      chk("next_pc", pc, m_pc);
      chk("next_rom_addr", rom_addr, m_pc);
      chk("next_valid", instr_valid, 0);
      if (gap) begin
        repeat (2) begin
          @(negedge clk);
          chk("idle_pc", pc, m_pc);
          chk("idle_valid", instr_valid, 0);
        end
        run = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic step0();
    exec_one(0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    reset_model();

    // Straight line with one run-low gap, then HALT
    fill_alu();
    put_word(8'h0C, ctl_word(6'h32, 8'h00));
    do_reset();
    step0();
    exec_one(0, 0, 1'b0, 8'h00, 1'b1, 1'b0);
    step0();
    step0();

    // Redirect at 0x10 to 0x14
    fill_alu();
    put_word(8'h18, ctl_word(6'h32, 8'h00));
    do_reset();
    repeat (4) step0();
    exec_one(0, 0, 1'b1, 8'h14, 1'b0, 1'b0);
    chk("redirect_rom_addr", rom_addr, 8'h14);
    step0();
    step0();

    // CALL at 0x08 to 0x20, RET back to 0x0C
    fill_alu();
    put_word(8'h08, ctl_word(6'h30, 8'h20));
    put_word(8'h20, ctl_word(6'h31, 8'h00));
    put_word(8'h0C, ctl_word(6'h32, 8'h00));
    do_reset();
    repeat (5) step0();
    chk("callret_fault", fault, 2'b00);

    // Nine nested CALLs overflow an 8-deep stack
    fill_alu();
    put_word(8'h00, ctl_word(6'h30, 8'h40));
    for (int k = 0; k < 8; k++) put_word(8'(8'h40 + 4*k), ctl_word(6'h30, 8'(8'h44 + 4*k)));
    do_reset();
    for (int k = 0; k < 12 && !m_dead; k++) step0();
    chk("overflow_fault", fault, 2'b01);

    // RET on empty stack
    fill_alu();
    put_word(8'h00, ctl_word(6'h31, 8'h00));
    do_reset();
    step0();
    chk("underflow_fault", fault, 2'b10);

    // Backpressure for 5 cycles at 0x24, HALT at 0x28
    fill_alu();
    put_word(8'h28, ctl_word(6'h32, 8'h00));
    do_reset();
    exec_one(0, 0, 1'b1, 8'h24, 1'b0, 1'b0);
    exec_one(5, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    step0();
    chk("halt_rom_addr", rom_addr, 8'h28);
    chk("halt_flag", halted, 1'b1);

    // Wrap 0xFC -> 0x00, async reset in EXEC, stack cleared by reset
    fill_alu();
    put_word(8'h00, ctl_word(6'h30, 8'hF8));
    do_reset();
    step0();
    step0();
    step0();
    chk("wrap_rom_addr", rom_addr, 8'h00);
    step0();
    exec_one(1, 0, 1'b0, 8'h00, 1'b0, 1'b1);
    put_word(8'h00, ctl_word(6'h31, 8'h00));
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    @(negedge clk);
    step0();
    chk("post_reset_underflow", fault, 2'b10);

    // Randomized programs
    for (int round = 0; round < 4; round++) begin
      for (int a = 0; a < 256; a += 4) begin
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 2)       put_word(8'(a), ctl_word(6'h30, 8'($urandom)));
        else if (r == 2) put_word(8'(a), ctl_word(6'h31, 8'h00));
        else if (r == 3 && a > 32) put_word(8'(a), ctl_word(6'h32, 8'h00));
        else             put_word(8'(a), alu_word());
      end
      do_reset();
      for (int s = 0; s < 40 && !m_dead; s++) begin
        exec_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), 8'($urandom),
                 ($urandom_range(0, 9) == 0), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
